servo_pwm_multi: RTL and testbench
==================================

// Module: servo_pwm_multi
// PURPOSE
//  Parametrised N-channel hobby-servo PWM generator; successor to the single-channel servo driver.
//  One shared prescaler and frame counter drive NUM_CH compare channels. Each channel has a
//  double-buffered position and enable, and updates only at frame boundaries, so pulses never glitch.
//  Sits between the arm joint controller (position writes) and the servo output pins.
// PARAMETERS
//  NUM_CH       4     number of servo channels
//  POS_W        8     position width per channel (unsigned)
//  TICK_DIV     195   clk cycles per tick (3.9 us at 50 MHz); must be >= 2
//  PERIOD_TICKS 5129  ticks per frame (~20 ms); must be > BASE_TICKS + ((2^POS_W-1) << GAIN_SHIFT)
//  BASE_TICKS   140   pulse width in ticks at pos=0
//  GAIN_SHIFT   1     ticks per LSB of pos = 2^GAIN_SHIFT
//  INIT_POS     0     reset value of shadow and active positions
//  SLEW_STEP    4     max change of active pos per frame (used only with SERVO_SLEW_LIMIT_EN)
// PORTS
//  clk          in   1              system clock, 50 MHz
//  rst_n        in   1              asynchronous reset, active low
//  pos_bus      in   NUM_CH*POS_W   packed positions; channel i = pos_bus[i*POS_W +: POS_W]
//  pos_valid    in   NUM_CH         per-channel strobe; loads that channel's shadow pos
//  enable       in   NUM_CH         per-channel output enable request
//  servo_pulse  out  NUM_CH         registered PWM outputs
//  frame_start  out  1              one-cycle pulse on the first cycle of each frame
// BEHAVIOUR
//  Clock/reset: one clock (clk). rst_n is asynchronous and active low.
//  Reset: all counters=0; shadow_pos=active_pos=INIT_POS; en_act=0; servo_pulse=0; frame_start=0.
//  Prescaler: div_cnt counts 0..TICK_DIV-1 and wraps. tick=1 for one cycle when div_cnt==TICK_DIV-1.
//  Frame counter: period_cnt, width clog2(PERIOD_TICKS). Increments on tick; wraps to 0 after PERIOD_TICKS-1.
//  Boundary: the cycle where tick && period_cnt==PERIOD_TICKS-1. On that edge:
//   - active_pos <= shadow_pos;
//   - en_act <= enable;
//   - frame_start <= 1 for one cycle, coincident with period_cnt==0.
//  Shadow: pos_valid[i] loads shadow_pos[i] on any cycle.
//   - A write on the boundary cycle lands in the shadow only; the active value takes the old shadow.
//   - So that write takes effect one frame later.
//   - Repeated writes within a frame: the last write wins.
//  Threshold: thr[i] = BASE_TICKS + (active_pos[i] << GAIN_SHIFT).
//   - Computed unsigned in POS_W+GAIN_SHIFT+1 bits, zero-extended before the compare. No saturation is needed.
//  Output: servo_pulse[i] <= en_act[i] && (period_cnt < thr[i]). Registered, one cycle after the counter.
//   - High time = thr*TICK_DIV clks. Period = PERIOD_TICKS*TICK_DIV clks.
//  After reset release, outputs stay low until the first boundary latches enable (one full frame).
//  enable dropped mid-frame: the current pulse completes normally; the output is low from the next frame.
//  rst_n asserted mid-pulse: servo_pulse goes to 0 asynchronously. The first new frame begins at release.
//  Elaboration check: $error if PERIOD_TICKS <= max threshold or TICK_DIV < 2.
// CONFIGURATION
//  SERVO_SLEW_LIMIT_EN defined: at each boundary, active_pos moves toward shadow_pos by at most SLEW_STEP.
//   - Step = min(|shadow-active|, SLEW_STEP), signed direction. No overshoot.
//   - Equal values mean no change. Protects the arm mechanics.
//  SERVO_SLEW_LIMIT_EN undefined: active_pos <= shadow_pos directly. SLEW_STEP is unused.
// TESTING (bench params: NUM_CH=2 POS_W=4 TICK_DIV=4 PERIOD_TICKS=64 BASE_TICKS=8 GAIN_SHIFT=1)
//  1 Reset, enable=2'b11, pos=0.
//    -> Both outputs low for frame 0. Then each frame is high 32 clks out of 256.
//    -> frame_start pulses every 256 clks.
//  2 Mid-frame pos_valid[0] with pos 5.
//    -> The current frame stays at 32 clks. The next frame ch0 is high 72 clks; ch1 is unchanged at 32.
//  3 pos_valid[1] with pos 3, asserted exactly on the boundary cycle.
//    -> The following frame is still 32 clks. The frame after is 56 clks.
//  4 enable[0] dropped at clk 10 of a pulse.
//    -> The pulse still lasts its full width. ch0 is low for all later frames. Re-enable returns it at the next boundary.
//  5 pos=15 on ch0.
//    -> High 152 clks. rst_n low mid-pulse drives servo_pulse=0 with no clk edge.
//    -> After release, outputs stay low for one frame.
//  6 With SERVO_SLEW_LIMIT_EN and SLEW_STEP=2, step pos 0 to 5.
//    -> Successive frames are high 32, 48, 64, 72, 72 clks. Then a step 5 to 0 gives 56, 40, 32.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel hobby-servo PWM generator.
// A shared prescaler and frame counter feed NUM_CH compare channels. Each
// channel double-buffers its position and enable; the active copies only
// change at the frame boundary, so a pulse in flight is never cut short or
// stretched by a write.
// Optional feature macro: SERVO_SLEW_LIMIT_EN. When defined, the active
// position moves toward the shadow position by at most SLEW_STEP per frame.
// When undefined, the shadow position is copied across unchanged.
//
// Write interface: pos_valid[i] is a single-cycle strobe with no ready. The
// block accepts it on every cycle, and the last strobe seen before a boundary
// edge decides the position for the next frame. A strobe on the boundary cycle
// itself only reaches the shadow register, so it takes effect one frame later.
module servo_pwm_multi #(
  parameter int NUM_CH       = 4,
  parameter int POS_W        = 8,
  parameter int TICK_DIV     = 195,
  parameter int PERIOD_TICKS = 5129,
  parameter int BASE_TICKS   = 140,
  parameter int GAIN_SHIFT   = 1,
  parameter int INIT_POS     = 0,
  parameter int SLEW_STEP    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*POS_W-1:0] pos_bus,
  input  logic [NUM_CH-1:0]       pos_valid,
  input  logic [NUM_CH-1:0]       enable,
  output logic [NUM_CH-1:0]       servo_pulse,
  output logic                    frame_start
);

  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PER_W   = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
  localparam int THR_W   = POS_W + GAIN_SHIFT + 1;
  localparam int CMP_W   = (THR_W > PER_W) ? THR_W : PER_W;
  localparam int MAX_THR = BASE_TICKS + ((2 ** POS_W - 1) << GAIN_SHIFT);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD_TICKS - 1);
  localparam logic [THR_W-1:0] BASE_T   = THR_W'(BASE_TICKS);
  localparam logic [POS_W-1:0] INIT_P   = POS_W'(INIT_POS);

  // Reject configurations where the widest pulse would fill the whole frame,
  // where the prescaler cannot divide, or where the slew step could not move.
  generate
    if (PERIOD_TICKS <= MAX_THR || TICK_DIV < 2 || SLEW_STEP < 1) begin : g_param_check
      $error("servo_pwm_multi: PERIOD_TICKS must exceed max threshold, TICK_DIV >= 2, SLEW_STEP >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;
  logic [PER_W-1:0] period_cnt;
  logic             tick;
  logic             boundary;

  logic [POS_W-1:0] shadow_pos  [NUM_CH];
  logic [POS_W-1:0] active_pos  [NUM_CH];
  logic [POS_W-1:0] next_active [NUM_CH];
  logic [THR_W-1:0] thr         [NUM_CH];
  logic [NUM_CH-1:0] en_act;

  // Tick on the last prescaler count; the boundary is the last tick of a frame.
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    boundary = tick && (period_cnt == PER_LAST);
  end

  // Prescaler: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame counter: advances once per tick and wraps after PERIOD_TICKS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= '0;
    end else if (tick) begin
      if (period_cnt == PER_LAST) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end

  // Shadow positions: any strobe loads its channel, last write in a frame wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_pos[i] <= INIT_P;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pos_valid[i]) begin
          shadow_pos[i] <= pos_bus[i*POS_W +: POS_W];
        end
      end
    end
  end

`ifdef SERVO_SLEW_LIMIT_EN
  logic [POS_W-1:0] slew_diff [NUM_CH];

  // Slew-limited update: step toward the shadow by at most SLEW_STEP, never past it.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      slew_diff[i]   = '0;
      next_active[i] = active_pos[i];
      if (shadow_pos[i] > active_pos[i]) begin
        slew_diff[i] = shadow_pos[i] - active_pos[i];
        if (int'(slew_diff[i]) > SLEW_STEP) begin
          next_active[i] = active_pos[i] + POS_W'(SLEW_STEP);
        end else begin
          next_active[i] = shadow_pos[i];
        end
      end else if (shadow_pos[i] < active_pos[i]) begin
        slew_diff[i] = active_pos[i] - shadow_pos[i];
        if (int'(slew_diff[i]) > SLEW_STEP) begin
          next_active[i] = active_pos[i] - POS_W'(SLEW_STEP);
        end else begin
          next_active[i] = shadow_pos[i];
        end
      end
    end
  end
`else
  // Direct update: the active position takes the shadow value as-is.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      next_active[i] = shadow_pos[i];
    end
  end
`endif

  // Active copies and frame_start change only on the boundary edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        active_pos[i] <= INIT_P;
      end
      en_act      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        for (int i = 0; i < NUM_CH; i++) begin
          active_pos[i] <= next_active[i];
        end
        en_act <= enable;
      end
    end
  end

  // Per-channel threshold in ticks; the width leaves room so no saturation is needed.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      thr[i] = BASE_T + (THR_W'(active_pos[i]) << GAIN_SHIFT);
    end
  end

  // Registered compare: high while the frame counter is below the threshold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      servo_pulse <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        servo_pulse[i] <= en_act[i] && (CMP_W'(period_cnt) < CMP_W'(thr[i]));
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a small configuration:
// 2 channels, 4-bit positions, 4 clks per tick, 64 ticks per frame (256 clks),
// base 8 ticks, 2 ticks per LSB. High time per frame = (8 + 2*pos) * 4 clks.
module tb_servo_pwm_multi;

  localparam int NUM_CH       = 2;
  localparam int POS_W        = 4;
  localparam int TICK_DIV     = 4;
  localparam int PERIOD_TICKS = 64;
  localparam int BASE_TICKS   = 8;
  localparam int GAIN_SHIFT   = 1;
  localparam int FRAME_CLKS   = TICK_DIV * PERIOD_TICKS;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_CH*POS_W-1:0] pos_bus;
  logic [NUM_CH-1:0]       pos_valid;
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       servo_pulse;
  logic                    frame_start;

  int checks;
  int passes;

  servo_pwm_multi #(
    .NUM_CH       (NUM_CH),
    .POS_W        (POS_W),
    .TICK_DIV     (TICK_DIV),
    .PERIOD_TICKS (PERIOD_TICKS),
    .BASE_TICKS   (BASE_TICKS),
    .GAIN_SHIFT   (GAIN_SHIFT),
    .INIT_POS     (0),
    .SLEW_STEP    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pos_bus     (pos_bus),
    .pos_valid   (pos_valid),
    .enable      (enable),
    .servo_pulse (servo_pulse),
    .frame_start (frame_start)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Release reset at a falling edge, then expect silence for exactly one frame.
  task automatic release_and_idle(input string name);
    int k;
    int hi;
    @(negedge clk);
    rst_n = 1'b1;
    k  = 0;
    hi = 0;
    while (k < 600) begin
      @(negedge clk);
      k++;
      if (servo_pulse !== 2'b00) hi++;
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (k !== FRAME_CLKS) $display("FAIL %s first_frame_start: got %0d clks want %0d", name, k, FRAME_CLKS);
    else passes++;
    checks++;
    if (hi !== 0) $display("FAIL %s idle_frame_high: got %0d clks want 0", name, hi);
    else passes++;
  endtask

  // Measure one frame starting at frame_start; optionally write a position or
  // change enable at a given cycle index within the frame.
  task automatic measure_frame(input string name, input int exp0, input int exp1,
                               input int wr_cycle, input logic [1:0] wr_mask,
                               input logic [7:0] wr_bus, input int en_cycle,
                               input logic [1:0] en_val);
    int w;
    int h0;
    int h1;
    int fs;
    w = 0;
    while (frame_start !== 1'b1 && w < 600) begin
      @(negedge clk);
      pos_valid = '0;
      w++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      $display("FAIL %s frame_start_wait: got 0 want 1 within 600 clks", name);
      return;
    end else passes++;
    h0 = 0;
    h1 = 0;
    fs = 0;
    for (int c = 0; c < FRAME_CLKS; c++) begin
      if (c > 0) @(negedge clk);
      if (servo_pulse[0] === 1'b1) h0++;
      if (servo_pulse[1] === 1'b1) h1++;
      if (frame_start === 1'b1) fs++;
      pos_valid = '0;
      if (c == wr_cycle) begin
        pos_bus   = wr_bus;
        pos_valid = wr_mask;
      end
      if (c == en_cycle) enable = en_val;
    end
    checks++;
    if (h0 !== exp0) $display("FAIL %s ch0_high: got %0d clks want %0d", name, h0, exp0);
    else passes++;
    checks++;
    if (h1 !== exp1) $display("FAIL %s ch1_high: got %0d clks want %0d", name, h1, exp1);
    else passes++;
    checks++;
    if (fs !== 1) $display("FAIL %s frame_start_count: got %0d want 1", name, fs);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    enable    = 2'b11;
    pos_valid = 2'b00;
    pos_bus   = 8'h00;
    #1;
    checks++;
    if (servo_pulse !== 2'b00) $display("FAIL reset_pulse: got %b want 00", servo_pulse);
    else passes++;
    checks++;
    if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b want 0", frame_start);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (servo_pulse !== 2'b00) $display("FAIL reset_hold_pulse: got %b want 00", servo_pulse);
    else passes++;
    release_and_idle("reset");
    measure_frame("reset_f1", 32, 32, -1, 2'b00, 8'h00, -1, 2'b11);
    measure_frame("reset_f2", 32, 32, -1, 2'b00, 8'h00, -1, 2'b11);
  endtask

  task automatic test_mid_frame_write();
    measure_frame("midwr_cur",  32, 32, 100, 2'b01, 8'h05, -1, 2'b11);
    measure_frame("midwr_next", 72, 32, -1,  2'b00, 8'h00, -1, 2'b11);
  endtask

  task automatic test_boundary_write();
    measure_frame("bndwr_cur",   72, 32, FRAME_CLKS - 1, 2'b10, 8'h30, -1, 2'b11);
    measure_frame("bndwr_next",  72, 32, -1, 2'b00, 8'h00, -1, 2'b11);
    measure_frame("bndwr_after", 72, 56, -1, 2'b00, 8'h00, -1, 2'b11);
  endtask

  task automatic test_enable_drop();
    measure_frame("endrop_cur",   72, 56, -1, 2'b00, 8'h00, 10,  2'b10);
    measure_frame("endrop_off",    0, 56, -1, 2'b00, 8'h00, 128, 2'b11);
    measure_frame("endrop_reen",  72, 56, -1, 2'b00, 8'h00, -1,  2'b11);
  endtask

  task automatic test_full_scale_reset();
    int w;
    measure_frame("full_cur",  72, 56, 50, 2'b01, 8'h0F, -1, 2'b11);
    measure_frame("full_next", 152, 56, -1, 2'b00, 8'h00, -1, 2'b11);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (frame_start !== 1'b1 && w < 600);
    repeat (100) @(negedge clk);
    checks++;
    if (servo_pulse !== 2'b01) $display("FAIL full_midpulse: got %b want 01", servo_pulse);
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (servo_pulse !== 2'b00) $display("FAIL async_reset_pulse: got %b want 00", servo_pulse);
    else passes++;
    checks++;
    if (frame_start !== 1'b0) $display("FAIL async_reset_frame_start: got %b want 0", frame_start);
    else passes++;
    repeat (3) @(negedge clk);
    release_and_idle("post_reset");
    measure_frame("post_reset_f1", 32, 32, -1, 2'b00, 8'h00, -1, 2'b11);
  endtask

  task automatic test_slew();
    int exp_q[$];
    exp_q = '{32, 48, 64, 72, 72, 56, 40, 32};
    for (int f = 0; f < 8; f++) begin
      if (f == 0)      measure_frame("slew_up",   exp_q[f], 32, 50, 2'b01, 8'h05, -1, 2'b11);
      else if (f == 4) measure_frame("slew_down", exp_q[f], 32, 50, 2'b01, 8'h00, -1, 2'b11);
      else             measure_frame("slew_step", exp_q[f], 32, -1, 2'b00, 8'h00, -1, 2'b11);
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
`ifdef SERVO_SLEW_LIMIT_EN
    test_slew();
`else
    test_mid_frame_write();
    test_boundary_write();
    test_enable_drop();
    test_full_scale_reset();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
